fft_frame_ctrl: RTL and testbench

Frame sequencer for the burst FFT core's Avalon-ST sink. It generates sink_valid/sink_sop/sink_eop and a sample read strobe/index for the sample buffer, and honours sink_ready backpressure. It waits for each transform's output eop before starting the next frame. It supports a programmed frame count or continuous operation, with a configurable idle gap between frames.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_beat_cnt.sv | 24 ++
 rtl/fft_frame_ctrl.sv | 125 ++++++++++++
 tb/tb_fft_frame_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sink frame sequencer: state encoding and default widths.
package fft_pkg;

    localparam int LEN_W = 16;
    localparam int GAP_W = 8;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_OUT = 2'd2,
        GAP      = 2'd3
    } state_t;

endpackage

// File: rtl/fft_beat_cnt.sv
// Loadable sample index counter: clears, advances on enable, wraps to zero after the terminal index.
module fft_beat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         term
);

    assign term = (idx == last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= term ? '0 : idx + W'(1);
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Avalon-ST sink frame sequencer for the burst FFT core: frames samples, honours backpressure,
// waits for each transform's output eop and spaces frames by a programmable idle gap.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int LEN_W   = fft_pkg::LEN_W,
    parameter int GAP_W   = fft_pkg::GAP_W,
    parameter int CNT_W   = fft_pkg::CNT_W,
    parameter int MIN_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cont_mode,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_frames,
    input  logic             sink_ready,
    output logic             sink_valid,
    output logic             sink_sop,
    output logic             sink_eop,
    output logic             sample_rd,
    output logic [LEN_W-1:0] sample_idx,
    input  logic             source_valid,
    input  logic             source_eop,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err
);

    state_t           state;
    logic [LEN_W-1:0] len_m1_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] frames_q;
    logic             cont_q;
    logic             stop_pend;
    logic             idx_term;
    logic             stop_any;

    assign sink_valid = (state == RUN);
    assign sink_sop   = sink_valid && (sample_idx == '0);
    assign sink_eop   = sink_valid && idx_term;
    assign sample_rd  = sink_valid && sink_ready;
    assign busy       = (state != IDLE);
    assign stop_any   = stop || stop_pend;

    fft_beat_cnt #(.W(LEN_W)) u_beat_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .en   (sample_rd),
        .last (len_m1_q),
        .idx  (sample_idx),
        .term (idx_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_m1_q   <= '0;
            gap_q      <= '0;
            gap_cnt    <= '0;
            frames_q   <= '0;
            cont_q     <= 1'b0;
            stop_pend  <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                IDLE: begin
                    stop_pend <= 1'b0;
                    if (start) begin
                        if (cfg_len < LEN_W'(MIN_LEN)) begin
                            cfg_err <= 1'b1;
                        end else begin
                            len_m1_q <= cfg_len - LEN_W'(1);
                            gap_q    <= cfg_gap;
                            frames_q <= (cfg_frames == '0) ? CNT_W'(1) : cfg_frames;
                            cont_q   <= cont_mode;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop) stop_pend <= 1'b1;
                    if (sample_rd && idx_term) state <= WAIT_OUT;
                end
                WAIT_OUT: begin
                    if (source_valid && source_eop) begin
                        frame_done <= 1'b1;
                        frames_q   <= frames_q - CNT_W'(1);
                        // The frame counter is checked before its decrement lands, so 1 means last.
                        if (stop_any || (!cont_q && frames_q == CNT_W'(1))) begin
                            state     <= IDLE;
                            stop_pend <= 1'b0;
                        end else if (gap_q != '0) begin
                            gap_cnt <= gap_q;
                            state   <= GAP;
                        end else begin
                            state <= RUN;
                        end
                    end else if (stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                GAP: begin
                    if (stop_any) begin
                        state     <= IDLE;
                        stop_pend <= 1'b0;
                    end else if (gap_cnt == GAP_W'(1)) begin
                        state <= RUN;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: a cycle vector table plus multi-frame sequences.
module tb_fft_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, stop, cont_mode;
    logic [15:0] cfg_len;
    logic [7:0]  cfg_gap, cfg_frames;
    logic        sink_ready, sink_valid, sink_sop, sink_eop, sample_rd;
    logic [15:0] sample_idx;
    logic        source_valid, source_eop, busy, frame_done, cfg_err;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    fft_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .cont_mode    (cont_mode),
        .cfg_len      (cfg_len),
        .cfg_gap      (cfg_gap),
        .cfg_frames   (cfg_frames),
        .sink_ready   (sink_ready),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sample_rd    (sample_rd),
        .sample_idx   (sample_idx),
        .source_valid (source_valid),
        .source_eop   (source_eop),
        .busy         (busy),
        .frame_done   (frame_done),
        .cfg_err      (cfg_err)
    );

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    typedef struct {
        int rst, start, stop, len, frames, ready, sv, se;
        int e_valid, e_sop, e_eop, e_rd, e_idx, e_busy, e_done, e_err;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [22:0] outs();
        return {sink_valid, sink_sop, sink_eop, sample_rd, busy, frame_done, cfg_err, sample_idx};
    endfunction

    task automatic start_run(input int len, input int gap, input int frames, input bit cont);
        @(negedge clk);
        start = 1'b1; stop = 1'b0; sink_ready = 1'b1;
        cfg_len = 16'(len); cfg_gap = 8'(gap); cfg_frames = 8'(frames); cont_mode = cont;
    endtask

    // Walk one frame beat by beat; counts idle cycles seen before its first valid beat.
    task automatic beat_frame(input int len, input bit tog, input int stop_at, input int exp_idle);
        int e = 0, k = 0, idle = 0, nrd = 0;
        bit started = 0, fin = 0, stopped = 0;
        for (int g = 0; g < 400 && !fin; g++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0; source_valid = 1'b0; source_eop = 1'b0;
            cfg_len = 16'd1;
            sink_ready = tog ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (started && e == stop_at && !stopped) begin
                stop = 1'b1;
                stopped = 1;
            end
            #1;
            if (!started && sink_valid !== 1'b1) begin
                idle++;
            end else begin
                started = 1;
                check("beat", {sink_valid, sink_sop, sink_eop, sample_rd, sample_idx},
                      {1'b1, e == 0, e == len - 1, sink_ready, 16'(e)});
                k++;
                if (sink_ready) begin
                    nrd++;
                    if (e == len - 1) fin = 1;
                    else e++;
                end
            end
        end
        check("beats_accepted", fin ? nrd : -1, len);
        check("idle_before_sop", idle, exp_idle);
    endtask

    task automatic deliver_eop(input int wait_n, input bit last);
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            source_valid = 1'b0; source_eop = 1'b0;
            #1;
            check("wait_out", {sink_valid, busy, frame_done}, 3'b010);
        end
        @(negedge clk);
        source_valid = 1'b1; source_eop = 1'b1;
        #1;
        check("eop_cycle", {sink_valid, busy, frame_done}, 3'b010);
        if (last) begin
            @(negedge clk);
            source_valid = 1'b0; source_eop = 1'b0;
            #1;
            check("last_done", {sink_valid, busy, frame_done}, 3'b001);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont_mode = 1'b0;
        cfg_len = '0; cfg_gap = '0; cfg_frames = '0; sink_ready = 1'b0;
        source_valid = 1'b0; source_eop = 1'b0;

        //          rst st sp len fr rdy sv se | vld sop eop rd idx busy done err
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 1, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 1, 2, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 2, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 5, 0, 1, 1, 1,    1, 1, 0, 1, 0, 1, 0, 0};
        tbl[6]  = '{0, 1, 0, 1, 0, 1, 0, 0,    1, 0, 1, 1, 1, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 0, 1, 0, 0,    0, 0, 0, 0, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 1, 1, 1,    0, 0, 0, 0, 0, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 1, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst = tbl[i].rst[0]; start = tbl[i].start[0]; stop = tbl[i].stop[0];
            cfg_len = 16'(tbl[i].len); cfg_frames = 8'(tbl[i].frames); cfg_gap = 8'd0;
            cont_mode = 1'b0; sink_ready = tbl[i].ready[0];
            source_valid = tbl[i].sv[0]; source_eop = tbl[i].se[0];
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].e_valid[0], tbl[i].e_sop[0], tbl[i].e_eop[0], tbl[i].e_rd[0],
                   tbl[i].e_busy[0], tbl[i].e_done[0], tbl[i].e_err[0], 16'(tbl[i].e_idx)});
        end

        // Single 8-sample frame, full throughput, late output eop
        done_cnt = 0;
        start_run(8, 0, 1, 0);
        beat_frame(8, 0, -1, 0);
        deliver_eop(20, 1);
        check("done_count_single", done_cnt, 1);

        // Same frame under 1,0,0,1 backpressure
        done_cnt = 0;
        start_run(8, 0, 1, 0);
        beat_frame(8, 1, -1, 0);
        deliver_eop(3, 1);
        check("done_count_bp", done_cnt, 1);

        // Three frames separated by a 5-cycle gap
        done_cnt = 0;
        start_run(4, 5, 3, 0);
        beat_frame(4, 0, -1, 0);
        deliver_eop(2, 0);
        beat_frame(4, 0, -1, 5);
        deliver_eop(2, 0);
        beat_frame(4, 0, -1, 5);
        deliver_eop(2, 1);
        check("done_count_gap", done_cnt, 3);

        // Continuous mode stopped mid-frame 2: frame 2 finishes, no frame 3
        done_cnt = 0;
        start_run(16, 0, 1, 1);
        beat_frame(16, 0, -1, 0);
        deliver_eop(3, 0);
        beat_frame(16, 0, 6, 0);
        deliver_eop(3, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("idle_after_stop", {sink_valid, busy}, 2'b00);
        end
        check("done_count_stop", done_cnt, 2);

        // Reset mid-frame at idx 3, then a clean restart
        start_run(8, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0; sink_ready = 1'b1;
            if (i == 3) rst = 1'b1;
            #1;
            if (i == 3) check("pre_reset_idx", {sink_valid, sample_idx}, {1'b1, 16'd3});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_reset", outs(), 23'd0);
        start_run(8, 0, 1, 0);
        beat_frame(8, 0, -1, 0);
        deliver_eop(2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
